serial_sub: RTL

Bit-serial N-bit subtractor with borrow-in/borrow-out. It is the subtract counterpart of the combinational ripple adders in the arithmetic labs. One full-subtractor cell and a borrow flip-flop process operands LSB-first, one bit per clock, trading N cycles of latency for a single-cell datapath. Operands enter and results leave through valid/ready handshakes, so the block drops between a register file and any consumer.

---
 rtl/serial_sub.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell per clock.
// Operands and result move through valid/ready handshakes.
module serial_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_sd;
  logic          r_br;
  logic [CW-1:0] r_cnt;

  logic [N-1:0] r_diff;
  logic         r_bout;
  logic         r_zero;
  logic         r_ovf;

  logic         w_x;
  logic         w_y;
  logic         w_d;
  logic         w_bn;
  logic [N-1:0] w_sd_nxt;
  logic         w_accept;
  logic         w_last;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_d      = w_x ^ w_y ^ r_br;
  assign w_bn     = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
  assign w_sd_nxt = {w_d, r_sd[N-1:1]};
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_state_nxt = RUN;
      RUN:  if (w_last) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: in_ready = 1'b1;
      RUN:  ;
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sd  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sa <= r_sa >> 1;
      r_sb <= r_sb >> 1;
      r_sd <= w_sd_nxt;
      r_br <= w_bn;
      // Counter parks at N-1 instead of wrapping.
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers change only when a result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_sd_nxt;
      r_bout <= w_bn;
      r_zero <= (w_sd_nxt == '0);
      r_ovf  <= r_br ^ w_bn;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf  = r_ovf;

endmodule
